// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and elaboration-time helpers for the
// UART receive path.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;

  // Rounded clocks per oversample tick.
  function automatic int baud_div(input int clk_hz, input int baud, input int os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

  function automatic int clog2(input int unsigned value);
    int r;
    r = 0;
    for (int unsigned p = 1; p < value; p = p << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous first-word fall-through FIFO with occupancy count; a push
// into a full FIFO is accepted only when a pop frees the head that cycle.
module sync_fifo import uart_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic [clog2(DEPTH):0]  count,
  output logic                   dropped
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  assign full     = (count == FULL_CNT);
  assign rd_valid = (count != '0);
  assign do_pop   = pop & rd_valid;
  assign do_push  = push & (~full | do_pop);
  assign dropped  = push & full & ~do_pop;
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver (configurable frame format, majority-vote
// sampling, frame/parity/overrun flags) feeding a receive FIFO.
module uart_rx_fifo import uart_pkg::*; #(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_25mhz,
  input  logic                          rst,
  input  logic                          rxd,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  input  logic                          clr_err
);

  localparam int DIV = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int DW  = clog2(DIV + 1);
  localparam int TW  = clog2(OVERSAMPLE + 1);
  localparam int BW  = clog2(DATA_BITS + 1);
  localparam bit HAS_PARITY = (PARITY != PARITY_NONE);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [TW-1:0] K_PRE    = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] K_MID    = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] K_POST   = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] K_END    = TW'(OVERSAMPLE);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  rx_state_t state, state_next;

  logic                 sync1, sync2, rx_prev, rx, fall;
  logic [DW-1:0]        div_cnt;
  logic                 tick;
  logic [TW-1:0]        tick_cnt, tick_num;
  logic                 at_pre, at_mid, at_post, at_end;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 bad, m0, m1, maj, par_exp;
  logic                 start_evt, shift_en, push, fe_set, pe_set, dropped;

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rxd;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  assign rx   = sync2;
  assign fall = rx_prev & ~rx;

  // Tick numbers run 1..OVERSAMPLE within each bit, counted from the start edge.
  assign tick     = (div_cnt == DIV_LAST);
  assign tick_num = tick_cnt + 1'b1;
  assign at_pre   = tick && (tick_num == K_PRE);
  assign at_mid   = tick && (tick_num == K_MID);
  assign at_post  = tick && (tick_num == K_POST);
  assign at_end   = tick && (tick_num == K_END);

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
    end else if (start_evt) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) tick_cnt <= (tick_num == K_END) ? '0 : tick_num;
    end
  end

  assign maj     = (m0 & m1) | (m0 & rx) | (m1 & rx);
  assign par_exp = (PARITY == PARITY_EVEN) ? ^shreg : ~^shreg;

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_evt  = 1'b0;
    shift_en   = 1'b0;
    push       = 1'b0;
    fe_set     = 1'b0;
    pe_set     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fall) begin
          state_next = ST_START;
          start_evt  = 1'b1;
        end
      end
      ST_START: begin
        if (at_mid && rx) state_next = ST_IDLE;
        else if (at_end)  state_next = ST_DATA;
      end
      ST_DATA: begin
        if (at_post) shift_en = 1'b1;
        if (at_end && bit_idx == BIT_LAST)
          state_next = HAS_PARITY ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (at_post && maj != par_exp) pe_set = 1'b1;
        if (at_end) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (at_mid) begin
          if (!rx) begin
            fe_set     = 1'b1;
            state_next = ST_WAIT_IDLE;
          end else if (stop_idx == 1'(STOP_BITS - 1)) begin
            push       = ~bad;
            state_next = ST_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (rx) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      m0         <= 1'b1;
      m1         <= 1'b1;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      bad        <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (at_pre) m0 <= rx;
      if (at_mid) m1 <= rx;
      if (start_evt) begin
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        bad      <= 1'b0;
      end else begin
        if (state == ST_DATA && at_end) bit_idx  <= bit_idx + 1'b1;
        if (state == ST_STOP && at_end) stop_idx <= 1'b1;
        if (pe_set) bad <= 1'b1;
      end
      if (shift_en) shreg <= {maj, shreg[DATA_BITS-1:1]};
      frame_err  <= fe_set;
      parity_err <= pe_set;
      if (dropped)      overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_25mhz),
    .rst      (rst),
    .push     (push),
    .wr_data  (shreg),
    .pop      (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (fifo_count),
    .dropped  (dropped)
  );

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised UART receiver with an integrated receive FIFO, clocked by clk_25mhz.
- Sits between the host serial line (ftdi_txd pin) and the terminal character decoder.
- Supersedes the fixed 8N1 receive path: configurable frame format, oversampling with majority vote, error flags and buffering for bursts arriving while the renderer is busy.

Parameters:
- CLK_HZ, 25000000, system clock frequency.
- BAUD, 115200, line rate.
- OVERSAMPLE, 16, sample ticks per bit; even, >=8.
- DATA_BITS, 8, data bits per frame; 5..9.
- PARITY, 0, 0=none, 1=odd, 2=even.
- STOP_BITS, 1, 1 or 2.
- FIFO_DEPTH, 16, entries; power of 2, >=2.

Ports:
- clk_25mhz  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rxd  in  1  asynchronous serial input; idle high.
- rd_en  in  1  pop request; ignored when rd_valid=0.
- rd_data  out  DATA_BITS  head-of-FIFO word; first-word fall-through.
- rd_valid  out  1  FIFO not empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- frame_err  out  1  one-cycle pulse; stop bit sampled low.
- parity_err  out  1  one-cycle pulse; parity mismatch.
- overrun  out  1  sticky; a byte was dropped because the FIFO was full.
- clr_err  in  1  clears overrun.

Behaviour:
- Reset values: rd_data=0, rd_valid=0, fifo_count=0, all error outputs 0, FSM=IDLE, synchroniser flops=1, divider=0.
- rxd passes through a 2-FF synchroniser, reset to 1. All sampling uses the synchronised value.
- Tick generator: DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)), giving 14 at the defaults. Emits a one-cycle tick every DIV clocks. Free-running; restarts at 0 on start-edge detection.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE -> START: on a synchronised falling edge.
- START: at tick OVERSAMPLE/2, a sample of 1 is a false start -> IDLE. A sample of 0 -> DATA.
- DATA: one bit per OVERSAMPLE ticks, LSB first. Each bit is the majority of the samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of that bit.
- DATA exit: goes to PARITY if PARITY!=0, otherwise to STOP.
- PARITY: samples the parity bit. A mismatch pulses parity_err and marks the frame bad.
- STOP: samples STOP_BITS stop bits. Any stop bit = 0 pulses frame_err, marks the frame bad and goes to WAIT_IDLE, which waits for the line to read 1 (break handling) before returning to IDLE.
- Good frame: pushed at the middle-sample tick of the last stop bit, then the FSM goes to IDLE. The next start edge may be accepted from the following clock.
- Bad frames are discarded and never pushed.
- Push latency: rd_valid and rd_data are updated in the cycle after the push.
- Push while full: the byte is dropped and overrun is set on the next clock.
- Push while full with rd_en=1 in the same cycle: pop and push both occur, no overrun, and fifo_count is unchanged.
- Simultaneous push and pop when not full: fifo_count is unchanged.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Full/empty are derived from fifo_count.
- clr_err clears overrun on the next clock. If an overrun occurs in the same cycle as clr_err, the set wins.
- Reset asserted mid-frame: the FSM returns to IDLE, the FIFO empties and the partial frame is lost with no error pulse.

Decomposition:
- Package uart_pkg:
  - PARITY_NONE/ODD/EVEN constants.
  - FSM state enum.
  - baud_div(clk_hz, baud, os) constant function.
  - clog2 helper.
- Sub-module sync_fifo: parametrised by WIDTH and DEPTH, with first-word fall-through, count, and the simultaneous push/pop-when-full rule above.
- The FSM, synchroniser and tick generator stay in uart_rx_fifo.

Test Plan:
- Defaults; send 8N1 0x55 at 224 clk/bit -> rd_valid rises within 2 cycles after the mid-stop sample; rd_data=0x55; fifo_count=1; no error pulses.
- Send 0x41 with stop bit held low, then line high after 2 bit times -> frame_err pulses exactly once; fifo_count stays 0; the next byte 0x42 is received correctly.
- PARITY=2; send 0x03 with parity bit 1 (wrong) -> parity_err pulses; byte discarded. Resend with parity bit 0 -> 0x03 received.
- FIFO_DEPTH=4; send 5 bytes 0x10..0x14 with rd_en=0 -> fifo_count=4, overrun=1; reads return 0x10..0x13. Pulse clr_err -> overrun=0.
- Glitch: rxd low for 3 clocks only -> false start, nothing pushed. Also a single-tick spike mid-bit during 0xA5 -> majority vote still yields 0xA5.
- Assert rst during bit 4 of a frame -> all outputs return to reset values; a following 0x7E is received cleanly.
